// File: rtl/stop_watch_ctrl.sv
// stop_watch_ctrl: run-control sequencer for the stopwatch datapath.
// Conditions the two raw buttons (sync, debounce, press detect) and runs the
// IDLE/RUN/LAP/PAUSE state machine. Drives the counter controls and selects
// the live time or a frozen lap snapshot for the display scan.
//
// Ports:
//   clk, sys_rstn              clock, async active-low reset
//   btn_ss, btn_lr             raw start/stop and lap/reset buttons (async)
//   sec_0..hr_1                live BCD time from the stopwatch counter
//   cnt_en, clr                count enable, one-cycle synchronous clear
//   d_sec_0..d_hr_1            time fields for the display (comb mux)
//   lap_active                 display is showing the lap snapshot
//   state                      FSM state (IDLE=0, RUN=1, LAP=2, PAUSE=3)
module stop_watch_ctrl #(
  parameter int unsigned DEB_CYCLES = 4_000_000
) (
  input  logic       clk,
  input  logic       sys_rstn,
  input  logic       btn_ss,
  input  logic       btn_lr,
  input  logic [3:0] sec_0,
  input  logic [2:0] sec_1,
  input  logic [3:0] min_0,
  input  logic [2:0] min_1,
  input  logic [3:0] hr_0,
  input  logic       hr_1,
  output logic       cnt_en,
  output logic       clr,
  output logic [3:0] d_sec_0,
  output logic [2:0] d_sec_1,
  output logic [3:0] d_min_0,
  output logic [2:0] d_min_1,
  output logic [3:0] d_hr_0,
  output logic       d_hr_1,
  output logic       lap_active,
  output logic [1:0] state
);

  localparam int unsigned CNT_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam int unsigned LAP_W = 19;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    LAP   = 2'd2,
    PAUSE = 2'd3
  } state_e;

  // Bit 0 carries start/stop, bit 1 carries lap/reset.
  logic [1:0]       btn_raw;
  logic [1:0]       meta_q;
  logic [1:0]       sync_q;
  logic [1:0]       deb_q;
  logic [1:0]       deb_prev_q;
  logic [1:0]       press_q;
  logic [CNT_W-1:0] cnt_q [2];

  logic             p_ss;
  logic             p_lr;
  logic [LAP_W-1:0] live_vec;

  state_e           state_q;
  logic             cnt_en_q;
  logic             clr_q;
  logic             lap_active_q;
  logic [LAP_W-1:0] lap_q;

  assign btn_raw  = {btn_lr, btn_ss};
  assign p_ss     = press_q[0];
  assign p_lr     = press_q[1];
  assign live_vec = {hr_1, hr_0, min_1, min_0, sec_1, sec_0};

  // Synchroniser, debounce counter and registered rising-edge press pulse.
  always_ff @(posedge clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      meta_q     <= '0;
      sync_q     <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      press_q    <= '0;
      cnt_q[0]   <= '0;
      cnt_q[1]   <= '0;
    end else begin
      meta_q     <= btn_raw;
      sync_q     <= meta_q;
      deb_prev_q <= deb_q;
      press_q    <= deb_q & ~deb_prev_q;
      for (int i = 0; i < 2; i++) begin
        // Any return to the accepted level restarts the stability count.
        if (sync_q[i] == deb_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_MAX) begin
          deb_q[i] <= sync_q[i];
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Run-control FSM with registered outputs; start/stop wins over lap/reset.
  always_ff @(posedge clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state_q      <= IDLE;
      cnt_en_q     <= 1'b0;
      clr_q        <= 1'b0;
      lap_active_q <= 1'b0;
      lap_q        <= '0;
    end else begin
      clr_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (p_ss) begin
            state_q  <= RUN;
            cnt_en_q <= 1'b1;
          end else if (p_lr) begin
            clr_q <= 1'b1;
          end
        end
        RUN: begin
          if (p_ss) begin
            state_q  <= PAUSE;
            cnt_en_q <= 1'b0;
          end else if (p_lr) begin
            state_q      <= LAP;
            lap_active_q <= 1'b1;
            lap_q        <= live_vec;
          end
        end
        LAP: begin
          if (p_ss) begin
            state_q      <= PAUSE;
            cnt_en_q     <= 1'b0;
            lap_active_q <= 1'b0;
          end else if (p_lr) begin
            state_q      <= RUN;
            lap_active_q <= 1'b0;
          end
        end
        PAUSE: begin
          if (p_ss) begin
            state_q  <= RUN;
            cnt_en_q <= 1'b1;
          end else if (p_lr) begin
            state_q <= IDLE;
            clr_q   <= 1'b1;
          end
        end
        default: begin
          state_q      <= IDLE;
          cnt_en_q     <= 1'b0;
          lap_active_q <= 1'b0;
        end
      endcase
    end
  end

  assign cnt_en     = cnt_en_q;
  assign clr        = clr_q;
  assign lap_active = lap_active_q;
  assign state      = state_q;

  // Display mux: frozen snapshot while in LAP, otherwise live pass-through.
  assign {d_hr_1, d_hr_0, d_min_1, d_min_0, d_sec_1, d_sec_0} =
    lap_active_q ? lap_q : live_vec;

endmodule

// File: tb/tb_stop_watch_ctrl.sv
// Testbench for stop_watch_ctrl with DEB_CYCLES = 4.
module tb_stop_watch_ctrl;

  localparam int unsigned DEB = 4;
  // Edge index (0 = first edge sampling the raw press) where the effect lands.
  localparam int EFFECT_K = DEB + 3;

  logic       clk = 1'b0;
  logic       sys_rstn;
  logic       btn_ss, btn_lr;
  logic [3:0] sec_0, min_0, hr_0;
  logic [2:0] sec_1, min_1;
  logic       hr_1;
  logic       cnt_en, clr, lap_active;
  logic [3:0] d_sec_0, d_min_0, d_hr_0;
  logic [2:0] d_sec_1, d_min_1;
  logic       d_hr_1;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  // Reference model: abstract state number and captured lap snapshot.
  int          m_state;
  logic [18:0] m_lap;

  stop_watch_ctrl #(.DEB_CYCLES(DEB)) dut (
    .clk(clk), .sys_rstn(sys_rstn), .btn_ss(btn_ss), .btn_lr(btn_lr),
    .sec_0(sec_0), .sec_1(sec_1), .min_0(min_0), .min_1(min_1),
    .hr_0(hr_0), .hr_1(hr_1),
    .cnt_en(cnt_en), .clr(clr),
    .d_sec_0(d_sec_0), .d_sec_1(d_sec_1), .d_min_0(d_min_0),
    .d_min_1(d_min_1), .d_hr_0(d_hr_0), .d_hr_1(d_hr_1),
    .lap_active(lap_active), .state(state)
  );

  always #5 clk = ~clk;

  function automatic logic [18:0] live_vec();
    return {hr_1, hr_0, min_1, min_0, sec_1, sec_0};
  endfunction

  function automatic logic [18:0] disp_vec();
    return {d_hr_1, d_hr_0, d_min_1, d_min_0, d_sec_1, d_sec_0};
  endfunction

  function automatic logic [4:0] exp_status(input int st, input logic c);
    logic run_like;
    run_like = (st == 1) || (st == 2);
    return {2'(st), run_like, (st == 2), c};
  endfunction

  function automatic logic [18:0] exp_disp();
    return (m_state == 2) ? m_lap : live_vec();
  endfunction

  task automatic rand_live();
    {hr_1, hr_0, min_1, min_0, sec_1, sec_0} = 19'($urandom);
  endtask

  // Press (ss, lr) held for 'hold' edges then released; checks timing and effect.
  task automatic do_press(input logic ss, input logic lr, input int hold,
                          input bit vary_live, input string tag);
    int          nxt;
    logic        exp_clr;
    bit          cap;
    logic [18:0] cap_val;
    nxt = m_state; exp_clr = 1'b0; cap = 1'b0; cap_val = '0;
    if (ss) begin
      nxt = (m_state == 0 || m_state == 3) ? 1 : 3;
    end else if (lr) begin
      case (m_state)
        0: exp_clr = 1'b1;
        1: begin nxt = 2; cap = 1'b1; end
        2: nxt = 1;
        default: begin nxt = 0; exp_clr = 1'b1; end
      endcase
    end
    @(negedge clk);
    btn_ss = ss; btn_lr = lr;
    for (int k = 0; k < hold; k++) begin
      if (vary_live) rand_live();
      if (k == EFFECT_K) cap_val = live_vec();
      @(posedge clk); #1;
      if (k == EFFECT_K - 1) begin
        checks++;
        if ({state, cnt_en, lap_active, clr} !== exp_status(m_state, 1'b0)) begin
          errors++;
          $display("FAIL %s early: status=%b required=%b", tag,
                   {state, cnt_en, lap_active, clr}, exp_status(m_state, 1'b0));
        end
      end
      if (k == EFFECT_K) begin
        m_state = nxt;
        if (cap) m_lap = cap_val;
        checks++;
        if ({state, cnt_en, lap_active, clr} !== exp_status(m_state, exp_clr)) begin
          errors++;
          $display("FAIL %s effect: status=%b required=%b", tag,
                   {state, cnt_en, lap_active, clr}, exp_status(m_state, exp_clr));
        end
        checks++;
        if (disp_vec() !== exp_disp()) begin
          errors++;
          $display("FAIL %s disp: d=%h required=%h", tag, disp_vec(), exp_disp());
        end
      end
      if (k == EFFECT_K + 1 || (k == hold - 1 && k > EFFECT_K + 1)) begin
        checks++;
        if ({state, cnt_en, lap_active, clr} !== exp_status(m_state, 1'b0)) begin
          errors++;
          $display("FAIL %s hold k=%0d: status=%b required=%b", tag, k,
                   {state, cnt_en, lap_active, clr}, exp_status(m_state, 1'b0));
        end
      end
      @(negedge clk);
    end
    btn_ss = 1'b0; btn_lr = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (vary_live) rand_live();
      @(negedge clk);
    end
    checks++;
    if ({state, cnt_en, lap_active, clr} !== exp_status(m_state, 1'b0) ||
        disp_vec() !== exp_disp()) begin
      errors++;
      $display("FAIL %s release: status=%b d=%h required=%b d=%h", tag,
               {state, cnt_en, lap_active, clr}, disp_vec(),
               exp_status(m_state, 1'b0), exp_disp());
    end
  endtask

  task automatic test_reset();
    sys_rstn = 1'b0; btn_ss = 1'b0; btn_lr = 1'b0;
    rand_live();
    #3;
    checks++;
    if ({state, cnt_en, lap_active, clr} !== 5'b0 || disp_vec() !== live_vec()) begin
      errors++;
      $display("FAIL reset: status=%b d=%h required=%b d=%h",
               {state, cnt_en, lap_active, clr}, disp_vec(), 5'b0, live_vec());
    end
    repeat (3) @(negedge clk);
    sys_rstn = 1'b1;
    m_state = 0; m_lap = '0;
  endtask

  task automatic test_debounce();
    bit moved;
    // Short glitch must be rejected.
    moved = 1'b0;
    @(negedge clk);
    btn_ss = 1'b1;
    repeat (DEB - 1) @(negedge clk);
    btn_ss = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (state !== 2'(m_state) || clr !== 1'b0 || cnt_en !== 1'b0) moved = 1'b1;
    end
    checks++;
    if (moved) begin
      errors++;
      $display("FAIL glitch: state moved to %0d required %0d", state, m_state);
    end
    do_press(1'b1, 1'b0, 12, 1'b1, "deb_start");
    do_press(1'b1, 1'b0, 100, 1'b1, "deb_hold100");
  endtask

  task automatic test_lap_capture();
    bit held;
    do_press(1'b1, 1'b0, 12, 1'b1, "lap_run");
    {hr_1, hr_0, min_1, min_0, sec_1, sec_0} = {1'b0, 4'd1, 3'd2, 4'd3, 3'd4, 4'd5};
    do_press(1'b0, 1'b1, 12, 1'b0, "lap_take");
    held = 1'b1;
    for (int k = 0; k < 10; k++) begin
      rand_live();
      @(posedge clk); #1;
      if (disp_vec() !== {1'b0, 4'd1, 3'd2, 4'd3, 3'd4, 4'd5} || cnt_en !== 1'b1 ||
          lap_active !== 1'b1) held = 1'b0;
    end
    checks++;
    if (!held) begin
      errors++;
      $display("FAIL lap_hold: d=%h lap=%b cnt_en=%b required=%h 1 1", disp_vec(),
               lap_active, cnt_en, {1'b0, 4'd1, 3'd2, 4'd3, 3'd4, 4'd5});
    end
    do_press(1'b0, 1'b1, 12, 1'b1, "lap_resume");
  endtask

  task automatic test_pause_reset();
    do_press(1'b1, 1'b0, 12, 1'b1, "pr_pause");
    do_press(1'b0, 1'b1, 12, 1'b1, "pr_clear");
    do_press(1'b1, 1'b0, 12, 1'b1, "pr_start");
  endtask

  task automatic test_lap_to_pause();
    do_press(1'b0, 1'b1, 12, 1'b1, "lp_lap");
    do_press(1'b1, 1'b0, 12, 1'b1, "lp_pause");
  endtask

  task automatic test_simultaneous();
    do_press(1'b1, 1'b0, 12, 1'b1, "sim_run");
    do_press(1'b1, 1'b1, 12, 1'b1, "sim_both");
    do_press(1'b1, 1'b1, 12, 1'b1, "sim_both2");
  endtask

  task automatic test_random();
    for (int n = 0; n < 25; n++) begin
      int sel;
      sel = int'($urandom_range(0, 3));
      do_press(sel != 1, sel != 0, int'($urandom_range(9, 16)), 1'b1, "random");
    end
  endtask

  task automatic test_reset_mid_run();
    if (m_state != 1) do_press(1'b1, 1'b0, 12, 1'b1, "rst_prep");
    if (m_state != 1) do_press(1'b1, 1'b0, 12, 1'b1, "rst_prep2");
    @(posedge clk); #3;
    sys_rstn = 1'b0;
    #1;
    checks++;
    if ({state, cnt_en, lap_active, clr} !== 5'b0 || disp_vec() !== live_vec()) begin
      errors++;
      $display("FAIL reset_mid: status=%b d=%h required=%b d=%h",
               {state, cnt_en, lap_active, clr}, disp_vec(), 5'b0, live_vec());
    end
    repeat (2) @(negedge clk);
    sys_rstn = 1'b1;
    m_state = 0; m_lap = '0;
    do_press(1'b1, 1'b0, 12, 1'b1, "post_reset");
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_lap_capture();
    test_pause_reset();
    test_lap_to_pause();
    test_simultaneous();
    test_random();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
